activation_collector: RTL

Downstream stage of the `mac` neuron datapath. Accepts one Qm.n neuron result per `mac` completion and applies the activation function (ReLU; leaky ReLU when compiled in). Stores each result into a NUM_NEURONS-deep output vector and presents the full vector to the next layer under a valid/ack handshake. The vector matches the `mac` `x` port format, so it can feed the next layer's `mac` instances directly.

---
 rtl/activation_collector.sv | 105 ++++++++++
 1 files changed

// File: rtl/activation_collector.sv
// Activation stage after the mac neurons: applies ReLU (leaky ReLU when LEAKY_RELU_EN
// is defined) and collects NUM_NEURONS results into a vector handed off via valid/ack.
module activation_collector #(
  parameter int NUM_NEURONS   = 4,
  parameter int FP_TOTAL_BITS = 16,
  parameter int FP_FRAC_BITS  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            in_valid,
  input  logic signed [FP_TOTAL_BITS-1:0] in_data,
  input  logic                            layer_ack,
  output logic signed [FP_TOTAL_BITS-1:0] act_vec [NUM_NEURONS],
  output logic                            layer_valid,
  output logic [$clog2(NUM_NEURONS)-1:0]  neuron_idx,
  output logic                            overflow
);

  localparam int IDX_W = $clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  generate
    if (NUM_NEURONS < 2 || FP_FRAC_BITS >= FP_TOTAL_BITS) begin : g_bad_cfg
      $error("activation_collector: NUM_NEURONS must be >= 2 and FP_FRAC_BITS < FP_TOTAL_BITS");
    end
  endgenerate

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state_p0, state_nxt;
  logic [IDX_W-1:0] idx_p0, idx_nxt;
  logic             ovf_p0, ovf_nxt;
  logic             wr_en;

  // Sign-based and bit-exact; the leaky slope is an arithmetic shift (floor of x/8).
  function automatic logic signed [FP_TOTAL_BITS-1:0] act(
    input logic signed [FP_TOTAL_BITS-1:0] x
  );
    if (!x[FP_TOTAL_BITS-1]) return x;
`ifdef LEAKY_RELU_EN
    return x >>> 3;
`else
    return '0;
`endif
  endfunction

  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    ovf_nxt   = ovf_p0;
    wr_en     = 1'b0;
    if (clear) begin
      state_nxt = COLLECT;
      idx_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state_p0)
        COLLECT: begin
          if (in_valid) begin
            wr_en = 1'b1;
            if (idx_p0 == LAST_IDX) begin
              idx_nxt   = '0;
              state_nxt = FULL;
            end else begin
              idx_nxt = idx_p0 + 1'b1;
            end
          end
        end
        FULL: begin
          if (in_valid)  ovf_nxt   = 1'b1;
          if (layer_ack) state_nxt = COLLECT;
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  // Stage p0: control state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0 <= COLLECT;
      idx_p0   <= '0;
      ovf_p0   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
      ovf_p0   <= ovf_nxt;
    end
  end

  // Stage p0: result vector, retained across clear and ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) act_vec[i] <= '0;
    end else if (wr_en) begin
      act_vec[idx_p0] <= act(in_data);
    end
  end

  assign layer_valid = (state_p0 == FULL);
  assign neuron_idx  = idx_p0;
  assign overflow    = ovf_p0;

endmodule
